// File: rtl/axi_midi_rx_ctrl.sv
// AXI4-Lite slave around a serial MIDI/UART receiver with RX FIFO,
// programmable baud divider, sticky error flags and threshold interrupt.
module axi_midi_rx_ctrl #(
  parameter int unsigned C_DATA_WIDTH   = 32,
  parameter int unsigned C_ADDR_WIDTH   = 4,
  parameter int unsigned C_LSB_FIRST    = 1,
  parameter int unsigned C_NUM_BITS     = 8,
  parameter int unsigned C_FIFO_DEPTH   = 16,
  parameter int unsigned C_CLKS_PER_BIT = 3200
) (
  input  logic                        s_axi_aclk,
  input  logic                        s_axi_areset,
  input  logic [C_ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic [2:0]                  s_axi_awprot,
  input  logic                        s_axi_awvalid,
  output logic                        s_axi_awready,
  input  logic [C_DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [C_DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                        s_axi_wvalid,
  output logic                        s_axi_wready,
  output logic [1:0]                  s_axi_bresp,
  output logic                        s_axi_bvalid,
  input  logic                        s_axi_bready,
  input  logic [C_ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic [2:0]                  s_axi_arprot,
  input  logic                        s_axi_arvalid,
  output logic                        s_axi_arready,
  output logic [C_DATA_WIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                  s_axi_rresp,
  output logic                        s_axi_rvalid,
  input  logic                        s_axi_rready,
  input  logic                        midi_in,
  output logic                        midi_intr
);

  localparam int unsigned PTR_W  = (C_FIFO_DEPTH > 1) ? $clog2(C_FIFO_DEPTH) : 1;
  localparam int unsigned LVL_W  = PTR_W + 1;
  localparam int unsigned DIV_W  = 16;
  localparam int unsigned BIDX_W = 4;
  localparam logic [1:0]  A_RXDATA = 2'd0;
  localparam logic [1:0]  A_STATUS = 2'd1;
  localparam logic [1:0]  A_CTRL   = 2'd2;
  localparam logic [1:0]  A_BAUD   = 2'd3;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // register file
  logic             ctrl_rx_en, ctrl_irq_en, flush_pend;
  logic [7:0]       ctrl_thresh;
  logic [DIV_W-1:0] baud_div;
  logic             sticky_ovf, sticky_ferr;

  // receiver
  rx_state_t             rx_state, rx_state_nxt;
  logic                  rx_s1, rx_s2, rx_s3;
  logic [DIV_W-1:0]      rx_cnt, rx_div;
  logic [BIDX_W-1:0]     rx_bit_idx;
  logic [C_NUM_BITS-1:0] rx_shift;
  logic                  rx_fall_c, rx_tick_c;
  logic                  rx_load_half_c, rx_reload_c, rx_sample_c, rx_push_c, rx_ferr_c;

  // fifo
  logic [C_NUM_BITS-1:0] fifo_mem [C_FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [LVL_W-1:0]      fifo_level;
  logic                  fifo_empty_c, fifo_full_c, do_push_c, pop_c, ovf_set_c;

  // axi
  logic                    wr_en_c, rd_pend;
  logic [1:0]              wr_sel_c, rd_addr;
  logic [DIV_W-1:0]        baud_merge_c, baud_wr_c;
  logic [C_DATA_WIDTH-1:0] rd_mux_c;
  logic                    unused_ok_c;

  assign s_axi_bresp = 2'b00;
  assign s_axi_rresp = 2'b00;
  assign unused_ok_c = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0],
                         s_axi_wdata[C_DATA_WIDTH-1:16], s_axi_wstrb[C_DATA_WIDTH/8-1:2]};

  // input synchroniser plus one delay stage for falling-edge detection
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= midi_in;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  assign rx_fall_c = rx_s3 & ~rx_s2;
  assign rx_tick_c = (rx_cnt == '0);

  // receiver state register
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) rx_state <= RX_IDLE;
    else              rx_state <= rx_state_nxt;
  end

  // receiver next-state logic
  always_comb begin
    rx_state_nxt = rx_state;
    unique case (rx_state)
      RX_IDLE:  if (rx_fall_c) rx_state_nxt = RX_START;
      RX_START: if (rx_tick_c) rx_state_nxt = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick_c && (rx_bit_idx == BIDX_W'(C_NUM_BITS - 1))) rx_state_nxt = RX_STOP;
      RX_STOP:  if (rx_tick_c) rx_state_nxt = RX_IDLE;
      default:  rx_state_nxt = RX_IDLE;
    endcase
  end

  // receiver per-state actions
  always_comb begin
    rx_load_half_c = 1'b0;
    rx_reload_c    = 1'b0;
    rx_sample_c    = 1'b0;
    rx_push_c      = 1'b0;
    rx_ferr_c      = 1'b0;
    unique case (rx_state)
      RX_IDLE:  rx_load_half_c = rx_fall_c;
      RX_START: rx_reload_c    = rx_tick_c & ~rx_s2;
      RX_DATA: begin
        rx_sample_c = rx_tick_c;
        rx_reload_c = rx_tick_c;
      end
      RX_STOP: begin
        rx_push_c = rx_tick_c & rx_s2 & ctrl_rx_en;
        rx_ferr_c = rx_tick_c & ~rx_s2;
      end
      default: ;
    endcase
  end

  // bit timer and shift register; divider is snapshotted at each start bit
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      rx_cnt     <= '0;
      rx_div     <= DIV_W'(C_CLKS_PER_BIT);
      rx_bit_idx <= '0;
      rx_shift   <= '0;
    end else begin
      if (rx_load_half_c) begin
        rx_div     <= baud_div;
        rx_cnt     <= baud_div >> 1;
        rx_bit_idx <= '0;
      end else if (rx_reload_c) begin
        rx_cnt <= rx_div - DIV_W'(1);
      end else if (!rx_tick_c) begin
        rx_cnt <= rx_cnt - DIV_W'(1);
      end
      if (rx_sample_c) begin
        rx_bit_idx <= rx_bit_idx + BIDX_W'(1);
        if (C_LSB_FIRST != 0) rx_shift <= {rx_s2, rx_shift[C_NUM_BITS-1:1]};
        else                  rx_shift <= {rx_shift[C_NUM_BITS-2:0], rx_s2};
      end
    end
  end

  assign fifo_empty_c = (fifo_level == '0);
  assign fifo_full_c  = (fifo_level == LVL_W'(C_FIFO_DEPTH));
  assign pop_c        = rd_pend & (rd_addr == A_RXDATA) & ~fifo_empty_c;
  assign do_push_c    = rx_push_c & (~fifo_full_c | pop_c) & ~flush_pend;
  assign ovf_set_c    = rx_push_c & fifo_full_c & ~pop_c & ~flush_pend;

  // fifo pointers and level; flush overrides push and pop
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset || flush_pend) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (do_push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)     rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push_c && !pop_c)      fifo_level <= fifo_level + LVL_W'(1);
      else if (!do_push_c && pop_c) fifo_level <= fifo_level - LVL_W'(1);
    end
  end

  // fifo storage
  always_ff @(posedge s_axi_aclk) begin
    if (do_push_c) fifo_mem[wr_ptr] <= rx_shift;
  end

  assign wr_en_c      = s_axi_awvalid & s_axi_wvalid & ~s_axi_bvalid & ~s_axi_awready;
  assign wr_sel_c     = s_axi_awaddr[3:2];
  assign baud_merge_c = {s_axi_wstrb[1] ? s_axi_wdata[15:8] : baud_div[15:8],
                         s_axi_wstrb[0] ? s_axi_wdata[7:0]  : baud_div[7:0]};
  assign baud_wr_c    = (baud_merge_c < DIV_W'(4)) ? DIV_W'(4) : baud_merge_c;

  // write channel handshake
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
    end else begin
      s_axi_awready <= wr_en_c;
      s_axi_wready  <= wr_en_c;
      if (s_axi_awready)                    s_axi_bvalid <= 1'b1;
      else if (s_axi_bvalid && s_axi_bready) s_axi_bvalid <= 1'b0;
    end
  end

  // register file updates and sticky status
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      ctrl_rx_en  <= 1'b1;
      ctrl_irq_en <= 1'b0;
      ctrl_thresh <= 8'd1;
      flush_pend  <= 1'b0;
      baud_div    <= DIV_W'(C_CLKS_PER_BIT);
      sticky_ovf  <= 1'b0;
      sticky_ferr <= 1'b0;
    end else begin
      flush_pend <= wr_en_c & (wr_sel_c == A_CTRL) & s_axi_wstrb[0] & s_axi_wdata[2];
      if (wr_en_c && (wr_sel_c == A_CTRL)) begin
        if (s_axi_wstrb[0]) begin
          ctrl_rx_en  <= s_axi_wdata[0];
          ctrl_irq_en <= s_axi_wdata[1];
        end
        if (s_axi_wstrb[1]) ctrl_thresh <= s_axi_wdata[15:8];
      end
      if (wr_en_c && (wr_sel_c == A_BAUD)) baud_div <= baud_wr_c;
      sticky_ovf  <= (sticky_ovf & ~(wr_en_c & (wr_sel_c == A_STATUS) & s_axi_wstrb[0] & s_axi_wdata[2]))
                     | ovf_set_c;
      sticky_ferr <= (sticky_ferr & ~(wr_en_c & (wr_sel_c == A_STATUS) & s_axi_wstrb[0] & s_axi_wdata[3]))
                     | rx_ferr_c;
    end
  end

  // read data mux
  always_comb begin
    rd_mux_c = '0;
    unique case (rd_addr)
      A_RXDATA: if (!fifo_empty_c) begin
        rd_mux_c[C_NUM_BITS-1:0]   = fifo_mem[rd_ptr];
        rd_mux_c[C_DATA_WIDTH-1]   = 1'b1;
      end
      A_STATUS: begin
        rd_mux_c[0]    = fifo_empty_c;
        rd_mux_c[1]    = fifo_full_c;
        rd_mux_c[2]    = sticky_ovf;
        rd_mux_c[3]    = sticky_ferr;
        rd_mux_c[15:8] = 8'(fifo_level);
      end
      A_CTRL: begin
        rd_mux_c[0]    = ctrl_rx_en;
        rd_mux_c[1]    = ctrl_irq_en;
        rd_mux_c[15:8] = ctrl_thresh;
      end
      A_BAUD:  rd_mux_c[DIV_W-1:0] = baud_div;
      default: rd_mux_c = '0;
    endcase
  end

  // read channel: address accept, then registered data one edge later
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      rd_pend       <= 1'b0;
      rd_addr       <= '0;
    end else begin
      s_axi_arready <= 1'b0;
      if (s_axi_arvalid && !s_axi_rvalid && !rd_pend && !s_axi_arready) begin
        s_axi_arready <= 1'b1;
        rd_addr       <= s_axi_araddr[3:2];
        rd_pend       <= 1'b1;
      end
      if (rd_pend) begin
        rd_pend      <= 1'b0;
        s_axi_rvalid <= 1'b1;
        s_axi_rdata  <= rd_mux_c;
      end else if (s_axi_rvalid && s_axi_rready) begin
        s_axi_rvalid <= 1'b0;
        s_axi_rdata  <= '0;
      end
    end
  end

  // registered interrupt
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) midi_intr <= 1'b0;
    else midi_intr <= ctrl_irq_en &
                      (((8'(fifo_level) >= ctrl_thresh) && (ctrl_thresh != 8'd0)) |
                       sticky_ovf | sticky_ferr);
  end

endmodule

// File: tb/tb_axi_midi_rx_ctrl.sv
// Directed bench for axi_midi_rx_ctrl: register access, reception, FIFO, IRQ, errors, reset.
module tb_axi_midi_rx_ctrl;

  localparam int unsigned BIT_CLKS = 16;

  logic        clk = 1'b0;
  logic        areset;
  logic [3:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        arvalid, arready, rvalid, rready;
  logic        midi_in, midi_intr;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  axi_midi_rx_ctrl dut (
    .s_axi_aclk(clk), .s_axi_areset(areset),
    .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .midi_in(midi_in), .midi_intr(midi_intr)
  );

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    int t;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    t = 0;
    while (!awready && t < 50) begin wait_clks(1); t++; end
    if (!awready) begin
      n_cmp++; n_err++;
      $display("FAIL awready_timeout: addr %h never accepted", a);
    end
    wait_clks(1);
    awvalid = 1'b0; wvalid = 1'b0;
    t = 0;
    while (!bvalid && t < 50) begin wait_clks(1); t++; end
    if (!bvalid) begin
      n_cmp++; n_err++;
      $display("FAIL bvalid_timeout: addr %h no response", a);
    end
    resp = bresp;
    bready = 1'b1;
    wait_clks(1);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d, output logic [1:0] resp);
    int t;
    araddr = a; arvalid = 1'b1;
    t = 0;
    while (!arready && t < 50) begin wait_clks(1); t++; end
    if (!arready) begin
      n_cmp++; n_err++;
      $display("FAIL arready_timeout: addr %h never accepted", a);
    end
    wait_clks(1);
    arvalid = 1'b0;
    t = 0;
    while (!rvalid && t < 50) begin wait_clks(1); t++; end
    if (!rvalid) begin
      n_cmp++; n_err++;
      $display("FAIL rvalid_timeout: addr %h no data", a);
    end
    d = rdata; resp = rresp;
    rready = 1'b1;
    wait_clks(1);
    rready = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    midi_in = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      midi_in = b[i];
      wait_clks(BIT_CLKS);
    end
    midi_in = stop_bit;
    wait_clks(BIT_CLKS);
    midi_in = 1'b1;
    wait_clks(BIT_CLKS);
  endtask

  task automatic test_reset;
    logic [31:0] d; logic [1:0] r;
    areset = 1'b1;
    wait_clks(5);
    areset = 1'b0;
    wait_clks(2);
    n_cmp++;
    if ({awready, wready, bvalid, arready, rvalid, midi_intr} !== 6'b0) begin
      n_err++; $display("FAIL reset_handshake: got %b expected 000000",
                        {awready, wready, bvalid, arready, rvalid, midi_intr});
    end
    n_cmp++;
    if (rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
    axi_read(4'h0, d, r);
    n_cmp++;
    if (d !== 32'h0) begin n_err++; $display("FAIL reset_rxdata: got %h expected 0", d); end
    n_cmp++;
    if (r !== 2'b00) begin n_err++; $display("FAIL reset_rresp: got %b expected 00", r); end
    axi_read(4'h4, d, r);
    n_cmp++;
    if (d !== 32'h0000_0001) begin n_err++; $display("FAIL reset_status: got %h expected 00000001", d); end
    axi_read(4'h8, d, r);
    n_cmp++;
    if (d !== 32'h0000_0101) begin n_err++; $display("FAIL reset_control: got %h expected 00000101", d); end
    axi_read(4'hC, d, r);
    n_cmp++;
    if (d !== 32'd3200) begin n_err++; $display("FAIL reset_baud: got %0d expected 3200", d); end
  endtask

  task automatic test_baud_regs;
    logic [31:0] d; logic [1:0] r;
    axi_write(4'hC, 32'h0000_0002, 4'hF, r);
    n_cmp++;
    if (r !== 2'b00) begin n_err++; $display("FAIL baud_bresp: got %b expected 00", r); end
    axi_read(4'hC, d, r);
    n_cmp++;
    if (d !== 32'd4) begin n_err++; $display("FAIL baud_clamp: got %0d expected 4", d); end
    axi_write(4'hC, 32'hFFFF_AB20, 4'h1, r);
    axi_read(4'hC, d, r);
    n_cmp++;
    if (d !== 32'h0000_0020) begin n_err++; $display("FAIL baud_wstrb: got %h expected 00000020", d); end
    axi_write(4'hC, 32'd16, 4'hF, r);
    axi_write(4'h0, 32'hDEAD_BEEF, 4'hF, r);
    n_cmp++;
    if (r !== 2'b00) begin n_err++; $display("FAIL rxdata_write_bresp: got %b expected 00", r); end
  endtask

  task automatic test_rx_basic;
    logic [31:0] d; logic [1:0] r;
    logic [31:0] exp_data [3];
    exp_data[0] = 32'h8000_0090; exp_data[1] = 32'h8000_003C; exp_data[2] = 32'h8000_007F;
    send_frame(8'h90, 1'b1);
    send_frame(8'h3C, 1'b1);
    send_frame(8'h7F, 1'b1);
    axi_read(4'h4, d, r);
    n_cmp++;
    if (d !== 32'h0000_0300) begin n_err++; $display("FAIL rx_level3: got %h expected 00000300", d); end
    for (int i = 0; i < 3; i++) begin
      axi_read(4'h0, d, r);
      n_cmp++;
      if (d !== exp_data[i]) begin
        n_err++; $display("FAIL rx_data%0d: got %h expected %h", i, d, exp_data[i]);
      end
    end
    axi_read(4'h0, d, r);
    n_cmp++;
    if (d !== 32'h0) begin n_err++; $display("FAIL rx_empty_read: got %h expected 0", d); end
    axi_read(4'h4, d, r);
    n_cmp++;
    if (d !== 32'h0000_0001) begin n_err++; $display("FAIL rx_drained: got %h expected 00000001", d); end
    n_cmp++;
    if (midi_intr !== 1'b0) begin n_err++; $display("FAIL rx_irq_off: got %b expected 0", midi_intr); end
  endtask

  task automatic test_irq;
    logic [31:0] d; logic [1:0] r;
    axi_write(4'h8, 32'h0000_0303, 4'hF, r);
    axi_read(4'h8, d, r);
    n_cmp++;
    if (d !== 32'h0000_0303) begin n_err++; $display("FAIL irq_ctrl_rb: got %h expected 00000303", d); end
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    n_cmp++;
    if (midi_intr !== 1'b0) begin n_err++; $display("FAIL irq_below: got %b expected 0", midi_intr); end
    send_frame(8'h33, 1'b1);
    n_cmp++;
    if (midi_intr !== 1'b1) begin n_err++; $display("FAIL irq_at_thresh: got %b expected 1", midi_intr); end
    axi_read(4'h0, d, r);
    n_cmp++;
    if (d !== 32'h8000_0011) begin n_err++; $display("FAIL irq_pop: got %h expected 80000011", d); end
    wait_clks(2);
    n_cmp++;
    if (midi_intr !== 1'b0) begin n_err++; $display("FAIL irq_clear: got %b expected 0", midi_intr); end
    axi_write(4'h8, 32'h0000_0105, 4'hF, r);
    axi_read(4'h4, d, r);
    n_cmp++;
    if (d !== 32'h0000_0001) begin n_err++; $display("FAIL irq_flush: got %h expected 00000001", d); end
  endtask

  task automatic test_overflow;
    logic [31:0] d; logic [1:0] r;
    for (int i = 0; i < 17; i++) send_frame(8'(i + 8'h40), 1'b1);
    axi_read(4'h4, d, r);
    n_cmp++;
    if (d !== 32'h0000_1006) begin n_err++; $display("FAIL ovf_status: got %h expected 00001006", d); end
    axi_write(4'h4, 32'h0000_0004, 4'hF, r);
    axi_read(4'h4, d, r);
    n_cmp++;
    if (d !== 32'h0000_1002) begin n_err++; $display("FAIL ovf_w1c: got %h expected 00001002", d); end
    axi_write(4'h8, 32'h0000_0105, 4'hF, r);
    axi_read(4'h4, d, r);
    n_cmp++;
    if (d !== 32'h0000_0001) begin n_err++; $display("FAIL ovf_flush: got %h expected 00000001", d); end
    axi_read(4'h8, d, r);
    n_cmp++;
    if (d !== 32'h0000_0101) begin n_err++; $display("FAIL flush_reads0: got %h expected 00000101", d); end
  endtask

  task automatic test_frame_err;
    logic [31:0] d; logic [1:0] r;
    axi_write(4'h8, 32'h0000_0003, 4'hF, r);
    send_frame(8'hA5, 1'b0);
    axi_read(4'h4, d, r);
    n_cmp++;
    if (d !== 32'h0000_0009) begin n_err++; $display("FAIL ferr_status: got %h expected 00000009", d); end
    n_cmp++;
    if (midi_intr !== 1'b1) begin n_err++; $display("FAIL ferr_irq: got %b expected 1", midi_intr); end
    axi_write(4'h4, 32'h0000_0008, 4'hF, r);
    wait_clks(2);
    n_cmp++;
    if (midi_intr !== 1'b0) begin n_err++; $display("FAIL ferr_irq_clear: got %b expected 0", midi_intr); end
    midi_in = 1'b0;
    wait_clks(1);
    midi_in = 1'b1;
    wait_clks(40);
    axi_read(4'h4, d, r);
    n_cmp++;
    if (d !== 32'h0000_0001) begin n_err++; $display("FAIL glitch_status: got %h expected 00000001", d); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] d; logic [1:0] r;
    int t;
    axi_write(4'h8, 32'h0000_0101, 4'hF, r);
    send_frame(8'h55, 1'b1);
    midi_in = 1'b0;
    wait_clks(20);
    araddr = 4'h0; arvalid = 1'b1;
    t = 0;
    while (!arready && t < 50) begin wait_clks(1); t++; end
    wait_clks(1);
    arvalid = 1'b0;
    n_cmp++;
    if (rvalid !== 1'b1) begin n_err++; $display("FAIL mid_rvalid_pre: got %b expected 1", rvalid); end
    areset = 1'b1;
    wait_clks(3);
    midi_in = 1'b1;
    wait_clks(1);
    areset = 1'b0;
    wait_clks(2);
    n_cmp++;
    if ({rvalid, bvalid, midi_intr} !== 3'b0) begin
      n_err++; $display("FAIL mid_reset_outs: got %b expected 000", {rvalid, bvalid, midi_intr});
    end
    axi_read(4'h4, d, r);
    n_cmp++;
    if (d !== 32'h0000_0001) begin n_err++; $display("FAIL mid_status: got %h expected 00000001", d); end
    axi_read(4'hC, d, r);
    n_cmp++;
    if (d !== 32'd3200) begin n_err++; $display("FAIL mid_baud: got %0d expected 3200", d); end
    axi_write(4'hC, 32'd16, 4'hF, r);
    send_frame(8'hC3, 1'b1);
    axi_read(4'h0, d, r);
    n_cmp++;
    if (d !== 32'h8000_00C3) begin n_err++; $display("FAIL mid_next_frame: got %h expected 800000C3", d); end
    axi_read(4'h4, d, r);
    n_cmp++;
    if (d !== 32'h0000_0001) begin n_err++; $display("FAIL mid_final_status: got %h expected 00000001", d); end
  endtask

  initial begin
    areset = 1'b1; midi_in = 1'b1;
    awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    wait_clks(1);
    test_reset;
    test_baud_regs;
    test_rx_basic;
    test_irq;
    test_overflow;
    test_frame_err;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
